led_pwm_wb: RTL and testbench

- Wishbone-slave LED controller; generalises the single-register LED block to NUM_CH independently configured channels.
- Per-channel modes: off, on, PWM dimming, blinking at PWM brightness.
- Shared prescaler, PWM counter and blink timebase.
- Sits on the peripheral Wishbone bus; drives board status/RGB LEDs directly.

---
 rtl/led_pwm_wb_if.sv | 28 ++
 rtl/led_pwm_wb.sv | 181 ++++++++++++++++++
 tb/tb_led_pwm_wb.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/led_pwm_wb_if.sv
// Wishbone classic slave bundle for the LED PWM controller.
// The slave modport receives address, data and strobes and returns data and ack/err/rty.
interface led_pwm_wb_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0]   wb_adr_i;
    logic [DATA_WIDTH-1:0]   wb_dat_i;
    logic [DATA_WIDTH-1:0]   wb_dat_o;
    logic                    wb_we_i;
    logic [SELECT_WIDTH-1:0] wb_sel_i;
    logic                    wb_stb_i;
    logic                    wb_cyc_i;
    logic                    wb_ack_o;
    logic                    wb_err_o;
    logic                    wb_rty_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );
endinterface

// File: rtl/led_pwm_wb.sv
// Multi-channel LED controller (off/on/PWM/blink) behind a Wishbone slave.
// Ack one clock after strobe (every other cycle when held); led_o lags registers/counters by one clock.
module led_pwm_wb #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int NUM_CH         = 7,
    parameter int PWM_BITS       = 8,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    led_pwm_wb_if.slave       wb,
    output logic [NUM_CH-1:0] led_o
);

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_PWM   = 2'd2;
    localparam logic [1:0] MODE_BLINK = 2'd3;

    // Control/config registers
    logic                      en;
    logic                      inv;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [7:0]                blink_per;
    logic [1:0]                ch_mode [NUM_CH];
    logic [PWM_BITS-1:0]       ch_duty [NUM_CH];

    // Shared timebase
    logic [PRESCALE_WIDTH-1:0] pre_cnt;
    logic [PWM_BITS-1:0]       pwm_cnt;
    logic [7:0]                blink_cnt;
    logic                      blink_phase;
    logic                      tick;
    logic                      frame_end;

    // Bus side
    logic                  ack_q;
    logic                  acc;
    logic                  wr;
    logic [3:0]            word;
    logic [DATA_WIDTH-1:0] rdata;
    logic [NUM_CH-1:0]     raw;
    logic                  unused_bits;

    assign word = wb.wb_adr_i[5:2];
    assign acc  = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    assign wr   = acc & wb.wb_we_i;

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = 1'b0;
    assign wb.wb_rty_o = 1'b0;

    assign unused_bits = ^{wb.wb_adr_i, wb.wb_dat_i, wb.wb_sel_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q       <= 1'b0;
            wb.wb_dat_o <= '0;
        end else begin
            ack_q <= acc;
            if (acc) begin
                wb.wb_dat_o <= rdata;
            end
        end
    end

    // Register file writes, byte lanes gated by sel
    always_ff @(posedge clk) begin
        if (rst) begin
            en        <= 1'b0;
            inv       <= 1'b0;
            prescale  <= '0;
            blink_per <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                ch_mode[n] <= MODE_OFF;
                ch_duty[n] <= '0;
            end
        end else if (wr) begin
            case (word)
                4'd0: begin
                    if (wb.wb_sel_i[0]) begin
                        en  <= wb.wb_dat_i[0];
                        inv <= wb.wb_dat_i[1];
                    end
                end
                4'd1: begin
                    for (int i = 0; i < PRESCALE_WIDTH; i++) begin
                        if (wb.wb_sel_i[i/8]) begin
                            prescale[i] <= wb.wb_dat_i[i];
                        end
                    end
                end
                4'd2: begin
                    if (wb.wb_sel_i[0]) begin
                        blink_per <= wb.wb_dat_i[7:0];
                    end
                end
                default: begin
                end
            endcase
            for (int n = 0; n < NUM_CH; n++) begin
                if (word == 4'(8 + n)) begin
                    if (wb.wb_sel_i[0]) begin
                        ch_mode[n] <= wb.wb_dat_i[1:0];
                    end
                    if (wb.wb_sel_i[1]) begin
                        ch_duty[n] <= wb.wb_dat_i[8 +: PWM_BITS];
                    end
                end
            end
        end
    end

    // Read mux; channel slots beyond NUM_CH fall through to zero
    always_comb begin
        rdata = '0;
        case (word)
            4'd0: rdata[1:0] = {inv, en};
            4'd1: rdata[PRESCALE_WIDTH-1:0] = prescale;
            4'd2: rdata[7:0] = blink_per;
            default: begin
                for (int n = 0; n < NUM_CH; n++) begin
                    if (word == 4'(8 + n)) begin
                        rdata[1:0]            = ch_mode[n];
                        rdata[8 +: PWM_BITS]  = ch_duty[n];
                    end
                end
            end
        endcase
    end

    // >= so that shrinking PRESCALE below the running count ticks immediately
    assign tick      = en & (pre_cnt >= prescale);
    assign frame_end = tick & (pwm_cnt == {PWM_BITS{1'b1}});

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            pre_cnt     <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            if (frame_end) begin
                if (blink_cnt == blink_per) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        raw = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            case (ch_mode[n])
                MODE_ON:    raw[n] = 1'b1;
                MODE_PWM:   raw[n] = (pwm_cnt < ch_duty[n]);
                MODE_BLINK: raw[n] = blink_phase & (pwm_cnt < ch_duty[n]);
                default:    raw[n] = 1'b0;
            endcase
            raw[n] = raw[n] & en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_o <= '0;
        end else begin
            led_o <= raw ^ {NUM_CH{inv}};
        end
    end

endmodule

// File: tb/tb_led_pwm_wb.sv
// Directed bench for led_pwm_wb: register map, handshake, PWM/blink duty counts, byte lanes, reset.
module tb_led_pwm_wb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] led_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    led_pwm_wb_if bus ();

    led_pwm_wb dut (
        .clk   (clk),
        .rst   (rst),
        .wb    (bus),
        .led_o (led_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_access(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                             input logic [3:0] sel, output logic [31:0] rdat, output int lat);
        bus.wb_adr_i = adr;
        bus.wb_dat_i = wdat;
        bus.wb_we_i  = we;
        bus.wb_sel_i = sel;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.wb_ack_o && lat < 20);
        if (!bus.wb_ack_o) check_eq("ack_timeout", 32'd0, 32'd1);
        rdat = bus.wb_dat_o;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] unused_r;
        int l;
        wb_access(adr, 1'b1, d, sel, unused_r, l);
    endtask

    task automatic rd(input logic [31:0] adr, output logic [31:0] d);
        int l;
        wb_access(adr, 1'b0, 32'd0, 4'hF, d, l);
    endtask

    task automatic count_led(input int bit_idx, input int cycles, output int lit);
        lit = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            if (led_o[bit_idx]) lit++;
        end
    endtask

    initial begin
        logic [31:0] d;
        int lat;
        int acks;
        int lit;
        int lit1;

        bus.wb_adr_i = '0;
        bus.wb_dat_i = '0;
        bus.wb_we_i  = 1'b0;
        bus.wb_sel_i = '0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_led", 32'(led_o), 32'h0);
        check_eq("rst_ack", 32'(bus.wb_ack_o), 32'h0);
        check_eq("rst_dat", bus.wb_dat_o, 32'h0);

        // Every offset reads zero after reset
        for (int a = 0; a < 16; a++) begin
            wb_access(32'(a * 4), 1'b0, 32'd0, 4'hF, d, lat);
            check_eq($sformatf("rst_read_%0h", a * 4), d, 32'h0);
            if (a == 0) begin
                check_eq("ack_latency", 32'(lat), 32'd1);
                @(posedge clk);
                #1;
                check_eq("ack_one_cycle", 32'(bus.wb_ack_o), 32'h0);
            end
        end
        check_eq("err_zero", 32'(bus.wb_err_o), 32'h0);
        check_eq("rty_zero", 32'(bus.wb_rty_o), 32'h0);

        // Held strobe: ack every other cycle
        bus.wb_adr_i = 32'h0;
        bus.wb_we_i  = 1'b0;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (bus.wb_ack_o) acks++;
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        check_eq("sustained_acks", 32'(acks), 32'd3);
        @(posedge clk);
        #1;

        // On mode and inversion
        wr(32'h00, 32'h1, 4'hF);
        wr(32'h20, 32'h1, 4'hF);
        check_eq("on_before", 32'(led_o), 32'h00);
        @(posedge clk);
        #1;
        check_eq("on_after", 32'(led_o), 32'h01);
        wr(32'h00, 32'h3, 4'hF);
        @(posedge clk);
        #1;
        check_eq("inv", 32'(led_o), 32'h7E);
        wr(32'h00, 32'h1, 4'hF);

        // PWM at PRESCALE=0: 256-clock frames
        wr(32'h24, 32'h0000_4002, 4'hF);
        repeat (4) @(posedge clk);
        count_led(1, 256, lit);
        check_eq("pwm_duty40", 32'(lit), 32'd64);
        wr(32'h24, 32'h0000_0002, 4'hF);
        repeat (4) @(posedge clk);
        count_led(1, 256, lit);
        check_eq("pwm_duty00", 32'(lit), 32'd0);
        wr(32'h24, 32'h0000_FF02, 4'hF);
        repeat (4) @(posedge clk);
        count_led(1, 256, lit);
        check_eq("pwm_dutyFF", 32'(lit), 32'd255);

        // Blink: 1024-clock frames, phase toggles every 2048 clocks, starting dark
        wr(32'h00, 32'h0, 4'hF);
        wr(32'h04, 32'h3, 4'hF);
        wr(32'h08, 32'h1, 4'hF);
        wr(32'h28, 32'h0000_FF03, 4'hF);
        wr(32'h00, 32'h1, 4'hF);
        count_led(2, 2000, lit);
        check_eq("blink_phase0_dark", 32'(lit), 32'd0);
        lit = 0;
        lit1 = 0;
        for (int k = 0; k < 4096; k++) begin
            @(posedge clk);
            #1;
            if (led_o[2]) lit++;
            if (k < 1024 && led_o[1]) lit1++;
        end
        check_eq("blink_period_lit", 32'(lit), 32'd2040);
        check_eq("pwm_prescale3", 32'(lit1), 32'd1020);
        rd(32'h04, d);
        check_eq("prescale_rb", d, 32'h3);
        rd(32'h08, d);
        check_eq("blink_rb", d, 32'h1);

        // Byte lanes
        wr(32'h2C, 32'hAABB_CC02, 4'b0001);
        rd(32'h2C, d);
        check_eq("sel0001", d, 32'h0000_0002);
        wr(32'h2C, 32'hAABB_CC02, 4'b0010);
        rd(32'h2C, d);
        check_eq("sel0010", d, 32'h0000_CC02);

        // Channel slot beyond NUM_CH
        wr(32'h00, 32'h0, 4'hF);
        wr(32'h3C, 32'h0000_FF01, 4'hF);
        rd(32'h3C, d);
        check_eq("ch7_read", d, 32'h0);
        @(posedge clk);
        #1;
        check_eq("ch7_led", 32'(led_o), 32'h0);

        // Reset in the middle of PWM activity
        wr(32'h04, 32'h0, 4'hF);
        wr(32'h24, 32'h0000_4002, 4'hF);
        wr(32'h00, 32'h3, 4'hF);
        repeat (100) @(posedge clk);
        rd(32'h24, d);
        check_eq("pre_rst_read", d, 32'h0000_4002);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst_led", 32'(led_o), 32'h0);
        check_eq("midrst_dat", bus.wb_dat_o, 32'h0);
        check_eq("midrst_ack", 32'(bus.wb_ack_o), 32'h0);
        rst = 1'b0;
        rd(32'h00, d);
        check_eq("post_rst_ctrl", d, 32'h0);
        rd(32'h24, d);
        check_eq("post_rst_ch1", d, 32'h0);
        count_led(1, 300, lit);
        check_eq("post_rst_dark", 32'(lit), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
